sram_write_buffer: RTL and testbench

//  Posted-write buffer and read arbiter that sits directly upstream of the SRAM controller.
//  CPU writes are queued in a FIFO and acknowledged at once; the queue drains to the SRAM

---
 rtl/sram_write_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_sram_write_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_buffer.sv
// Posted-write FIFO in front of the SRAM controller: writes are acknowledged on entry and
// drained in the background, reads are forwarded from the FIFO or served ahead of queued writes.
module sram_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_sram_request,
  output logic        o_sram_rw,
  output logic [31:0] o_sram_address,
  output logic [31:0] o_sram_wdata,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_sram_ready,
  output logic        o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE, GAP} state_t;

  state_t            state_reg, state_next;
  logic [29:0]       addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              acked_reg, acked_next;
  logic              read_pending_reg, read_pending_next;
  logic [29:0]       read_addr_reg;

  logic              ready_next;
  logic [31:0]       rdata_next;
  logic              sram_request_next, sram_rw_next;
  logic [31:0]       sram_address_next, sram_wdata_next;

  logic              accept, push, pop, read_req, fifo_full;
  logic              hit;
  logic [31:0]       hit_data;
  logic [DEPTH-1:0]  match;
  logic [31:0]       age_data [DEPTH];
  logic [29:0]       req_word;
  logic              unused_addr_bits;

  assign req_word         = i_address[31:2];
  assign unused_addr_bits = &{1'b0, i_address[1:0]};
  assign fifo_full        = (count_reg == (PTR_W+1)'(DEPTH));

  // acked blocks re-accepting a request the CPU is still holding after its ack
  assign accept   = i_request && !acked_reg && !read_pending_reg;
  assign push     = accept && i_rw && !fifo_full;
  assign read_req = accept && !i_rw;

  // Entries viewed oldest (gi=0) to newest, so the highest matching index is the newest write
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] idx;
      assign idx          = rd_ptr_reg + PTR_W'(gi);
      assign match[gi]    = (count_reg > (PTR_W+1)'(gi)) && (addr_mem[idx] == req_word);
      assign age_data[gi] = data_mem[idx];
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit      = 1'b1;
        hit_data = age_data[k];
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    sram_request_next = o_sram_request;
    sram_rw_next      = o_sram_rw;
    sram_address_next = o_sram_address;
    sram_wdata_next   = o_sram_wdata;
    ready_next        = 1'b0;
    rdata_next        = o_rdata;
    read_pending_next = read_pending_reg;
    acked_next        = acked_reg;
    pop               = 1'b0;

    if (push) begin
      ready_next = 1'b1;
    end
    if (read_req) begin
      if (hit) begin
        ready_next = 1'b1;
        rdata_next = hit_data;
      end else begin
        read_pending_next = 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (read_pending_reg) begin
          state_next        = READ;
          sram_request_next = 1'b1;
          sram_rw_next      = 1'b0;
          sram_address_next = {read_addr_reg, 2'b00};
        end else if (count_reg != '0) begin
          state_next        = WRITE;
          sram_request_next = 1'b1;
          sram_rw_next      = 1'b1;
          sram_address_next = {addr_mem[rd_ptr_reg], 2'b00};
          sram_wdata_next   = data_mem[rd_ptr_reg];
        end
      end
      READ: begin
        if (i_sram_ready) begin
          state_next        = GAP;
          sram_request_next = 1'b0;
          sram_rw_next      = 1'b0;
          rdata_next        = i_sram_rdata;
          ready_next        = 1'b1;
          read_pending_next = 1'b0;
        end
      end
      WRITE: begin
        if (i_sram_ready) begin
          state_next        = GAP;
          sram_request_next = 1'b0;
          sram_rw_next      = 1'b0;
          pop               = 1'b1;
        end
      end
      default: begin
        state_next        = IDLE;
        sram_request_next = 1'b0;
        sram_rw_next      = 1'b0;
      end
    endcase

    if (!i_request) begin
      acked_next = 1'b0;
    end else if (ready_next) begin
      acked_next = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg        <= IDLE;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      acked_reg        <= 1'b0;
      read_pending_reg <= 1'b0;
      read_addr_reg    <= '0;
      o_ready          <= 1'b0;
      o_rdata          <= '0;
      o_sram_request   <= 1'b0;
      o_sram_rw        <= 1'b0;
      o_sram_address   <= '0;
      o_sram_wdata     <= '0;
    end else begin
      state_reg        <= state_next;
      acked_reg        <= acked_next;
      read_pending_reg <= read_pending_next;
      o_ready          <= ready_next;
      o_rdata          <= rdata_next;
      o_sram_request   <= sram_request_next;
      o_sram_rw        <= sram_rw_next;
      o_sram_address   <= sram_address_next;
      o_sram_wdata     <= sram_wdata_next;
      if (read_req && !hit) begin
        read_addr_reg <= req_word;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= req_word;
      data_mem[wr_ptr_reg] <= i_wdata;
    end
  end

  assign o_empty = (count_reg == '0) && (state_reg == IDLE) && !read_pending_reg;

endmodule

// File: tb/tb_sram_write_buffer.sv
// Bench for sram_write_buffer: directed scenarios plus random traffic checked against a
// last-written-value shadow memory and a behavioural SRAM controller.
module tb_sram_write_buffer;

  logic        clk = 1'b0;
  logic        i_reset, i_request, i_rw, i_sram_ready;
  logic [31:0] i_address, i_wdata, i_sram_rdata;
  logic [31:0] o_rdata, o_sram_address, o_sram_wdata;
  logic        o_ready, o_sram_request, o_sram_rw, o_empty;

  always #5 clk = ~clk;

  sram_write_buffer #(.DEPTH(4)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
    .i_address(i_address), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready),
    .o_sram_request(o_sram_request), .o_sram_rw(o_sram_rw), .o_sram_address(o_sram_address),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata), .i_sram_ready(i_sram_ready),
    .o_empty(o_empty)
  );

  typedef struct {logic rw; logic [31:0] addr; logic [31:0] data;} op_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_sram_wr = 0;
  int n_sram_rd = 0;
  int n_acked = 0;
  op_t log_q[$];
  int wr_cyc_q[$];
  logic [31:0] mem [int unsigned];
  logic [31:0] shadow [int unsigned];
  logic sram_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    logic [31:0] w = a & ~32'h3;
    if (shadow.exists(w)) return shadow[w];
    return init_val(w);
  endfunction

  // SRAM controller model plus downstream protocol monitor
  initial begin : sram_model
    int lat_left = 0;
    logic gap_expect = 1'b0;
    logic prev_req = 1'b0;
    logic prev_rw = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    i_sram_ready = 1'b0;
    i_sram_rdata = '0;
    forever begin
      @(negedge clk);
      if (!o_sram_request) check("sram_rw_idle", 32'(o_sram_rw), 0);
      if (o_sram_request && prev_req && !i_sram_ready) begin
        check("sram_addr_stable", o_sram_address, prev_addr);
        check("sram_rw_stable", 32'(o_sram_rw), 32'(prev_rw));
        if (o_sram_rw) check("sram_wdata_stable", o_sram_wdata, prev_wdata);
      end
      if (gap_expect) begin
        check("sram_gap", 32'(o_sram_request), 0);
        gap_expect = 1'b0;
      end
      if (i_sram_ready) begin
        i_sram_ready = 1'b0;
      end else if (!o_sram_request || i_reset) begin
        lat_left = $urandom_range(0, 3);
      end else if (!sram_stall) begin
        if (lat_left == 0) begin
          i_sram_ready = 1'b1;
          gap_expect = 1'b1;
          if (o_sram_rw) begin
            mem[o_sram_address] = o_sram_wdata;
            n_sram_wr++;
            wr_cyc_q.push_back(cyc);
          end else begin
            i_sram_rdata = mem_rd(o_sram_address);
            n_sram_rd++;
          end
          log_q.push_back('{o_sram_rw, o_sram_address, o_sram_wdata});
        end else begin
          lat_left--;
        end
      end
      prev_req = o_sram_request;
      prev_rw = o_sram_rw;
      prev_addr = o_sram_address;
      prev_wdata = o_sram_wdata;
    end
  end

  // One CPU transaction, started and finished on a falling edge
  task automatic cpu_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd, output int lat, output int ack_cyc);
    i_request = 1'b1;
    i_rw = rw;
    i_address = addr;
    i_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_ready && lat < 300);
    if (!o_ready) check("ack_timeout", 32'(o_ready), 1);
    rd = o_rdata;
    ack_cyc = cyc;
    repeat (hold) begin
      @(negedge clk);
      check("single_ack", 32'(o_ready), 0);
    end
    i_request = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(o_ready), 0);
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] wd, input int hold,
                           output int lat, output int ack_cyc);
    logic [31:0] rd;
    cpu_txn(1'b1, addr, wd, hold, rd, lat, ack_cyc);
    shadow[addr & ~32'h3] = wd;
    n_acked++;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!o_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(o_empty), 1);
  endtask

  logic [31:0] rd, rd5;
  int lat, ac, lat5, ac5, base, lbase;

  initial begin
    i_reset = 1'b1;
    i_request = 1'b0;
    i_rw = 1'b0;
    i_address = '0;
    i_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_sram_req", 32'(o_sram_request), 0);
    check("rst_sram_rw", 32'(o_sram_rw), 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_sram_addr", o_sram_address, 0);
    check("rst_sram_wdata", o_sram_wdata, 0);
    check("rst_empty", 32'(o_empty), 1);
    i_reset = 1'b0;
    @(negedge clk);

    // single posted write drains to SRAM
    base = n_sram_wr;
    cpu_write(32'h100, 32'hDEADBEEF, 0, lat, ac);
    check("t1_ack_lat", lat, 1);
    wait_empty();
    check("t1_wr_count", n_sram_wr - base, 1);
    check("t1_addr", log_q[$].addr, 32'h100);
    check("t1_data", log_q[$].data, 32'hDEADBEEF);
    check("t1_rw", 32'(log_q[$].rw), 1);

    // newest queued write forwarded to a read
    sram_stall = 1'b1;
    cpu_write(32'h10, 32'h1, 0, lat, ac);
    cpu_write(32'h10, 32'h2, 0, lat, ac);
    base = n_sram_rd;
    cpu_txn(1'b0, 32'h10, 32'h0, 0, rd, lat, ac);
    check("t2_fwd_data", rd, 32'h2);
    check("t2_fwd_lat", lat, 1);
    check("t2_no_sram_rd", n_sram_rd - base, 0);
    sram_stall = 1'b0;
    wait_empty();

    // full FIFO stalls the fifth write until the first pop
    sram_stall = 1'b1;
    base = wr_cyc_q.size();
    for (int i = 0; i < 4; i++) begin
      cpu_write(32'h400 + 32'(4 * i), $urandom, 0, lat, ac);
      check("t3_ack_lat", lat, 1);
    end
    check("t3_not_empty", 32'(o_empty), 0);
    fork
      begin
        cpu_txn(1'b1, 32'h410, 32'h5555_AAAA, 0, rd5, lat5, ac5);
      end
      begin
        repeat (10) @(negedge clk);
        sram_stall = 1'b0;
      end
    join
    shadow[32'h410] = 32'h5555_AAAA;
    n_acked++;
    check("t3_stalled", 32'(lat5 > 10), 1);
    if (wr_cyc_q.size() > base) check("t3_ack_after_pop", ac5, wr_cyc_q[base] + 2);
    else check("t3_pop_seen", wr_cyc_q.size(), base + 1);
    wait_empty();

    // read miss overtakes queued writes once the in-flight write finishes
    sram_stall = 1'b1;
    cpu_write(32'h300, 32'h3000_0001, 0, lat, ac);
    cpu_write(32'h304, 32'h3000_0002, 0, lat, ac);
    cpu_write(32'h308, 32'h3000_0003, 0, lat, ac);
    lbase = log_q.size();
    fork
      begin
        cpu_txn(1'b0, 32'h200, 32'h0, 0, rd, lat, ac);
      end
      begin
        repeat (5) @(negedge clk);
        sram_stall = 1'b0;
      end
    join
    check("t4_rdata", rd, init_val(32'h200));
    wait_empty();
    check("t4_op_count", log_q.size() - lbase, 4);
    if (log_q.size() - lbase >= 4) begin
      check("t4_op0_addr", log_q[lbase].addr, 32'h300);
      check("t4_op1_rw", 32'(log_q[lbase+1].rw), 0);
      check("t4_op1_addr", log_q[lbase+1].addr, 32'h200);
      check("t4_op2_addr", log_q[lbase+2].addr, 32'h304);
      check("t4_op3_addr", log_q[lbase+3].addr, 32'h308);
    end

    // held request yields exactly one write
    base = n_sram_wr;
    cpu_write(32'h500, 32'h0BAD_F00D, 3, lat, ac);
    wait_empty();
    check("t5_one_push", n_sram_wr - base, 1);

    // random traffic over a small address pool to exercise forwarding and ordering
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, d, e;
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        cpu_write(a, d, $urandom_range(0, 2), lat, ac);
      end else begin
        e = sh_rd(a);
        cpu_txn(1'b0, a, 32'h0, $urandom_range(0, 2), rd, lat, ac);
        check("rand_rd", rd, e);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_empty();
    for (int k = 0; k < 8; k++) begin
      check("final_mem", mem_rd(32'h1000 + 32'(4 * k)), sh_rd(32'h1000 + 32'(4 * k)));
    end
    check("wr_total", n_sram_wr, n_acked);

    // reset mid-write discards the queue
    sram_stall = 1'b1;
    base = n_sram_wr;
    cpu_write(32'h600, 32'h6666_0000, 0, lat, ac);
    cpu_write(32'h604, 32'h6666_0004, 0, lat, ac);
    check("t6_mid_write", 32'(o_sram_request), 1);
    i_reset = 1'b1;
    @(negedge clk);
    check("t6_req_low", 32'(o_sram_request), 0);
    check("t6_empty", 32'(o_empty), 1);
    i_reset = 1'b0;
    sram_stall = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_writes", n_sram_wr - base, 0);
    check("t6_still_empty", 32'(o_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
